// File: rtl/ahb_slave_mem_ws.sv
// AHB-Lite slave memory with runtime wait states, byte-lane writes, a write-protected
// low region and two-cycle ERROR responses.
module ahb_slave_mem_ws #(
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned WSWIDTH  = 4,
   parameter int unsigned RO_WORDS = 0,
   parameter int unsigned CNTWIDTH = 16
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic                HSEL,
   input  logic [AWIDTH-1:0]   HADDR,
   input  logic                HWRITE,
   input  logic [1:0]          HTRANS,
   input  logic [2:0]          HSIZE,
   input  logic [2:0]          HBURST,
   input  logic [31:0]         HWDATA,
   input  logic                HREADYIN,
   input  logic [WSWIDTH-1:0]  WAIT_CFG,
   output logic                HREADYOUT,
   output logic [31:0]         HRDATA,
   output logic                HRESP,
   output logic [CNTWIDTH-1:0] ERR_COUNT
);
   localparam int unsigned IW  = AWIDTH - 2;
   localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t             state;
   logic [IW-1:0]      a_idx;
   logic [3:0]         a_mask;
   logic               a_write;
   logic [WSWIDTH-1:0] ws_cnt;
   logic [31:0]        mem [DEPTH];

   logic               accept_c;
   logic               err_c;
   logic               ro_hit_c;
   logic               wr_commit_c;
   logic [IW-1:0]      idx_c;
   logic [3:0]         mask_c;
   logic [31:0]        rd_fwd_c;
   logic               unused_c;

   assign unused_c = ^{HBURST, HTRANS[0]};

   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
      case (size)
         3'b000:  lane_mask = 4'b0001 << lane;
         3'b001:  lane_mask = lane[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   if (RO_WORDS == 0) begin : g_no_ro
      assign ro_hit_c = 1'b0;
   end else begin : g_ro
      assign ro_hit_c = (32'(idx_c) < RO_WORDS);
   end

   // Address-phase decode; read data forwards a write committing on this same edge.
   always_comb begin
      idx_c       = HADDR[AWIDTH-1:2];
      mask_c      = lane_mask(HSIZE, HADDR[1:0]);
      accept_c    = HSEL && HREADYIN && HTRANS[1] &&
                    (state == S_IDLE || state == S_DATA || state == S_ERR2);
      err_c       = (32'(idx_c) >= DEPTH) || (HSIZE > 3'b010) ||
                    (HSIZE == 3'b001 && HADDR[0]) ||
                    (HSIZE == 3'b010 && HADDR[1:0] != 2'b00) ||
                    (HWRITE && ro_hit_c);
      wr_commit_c = (state == S_DATA) && a_write;
      rd_fwd_c    = mem[MAW'(idx_c)];
      if (wr_commit_c && a_idx == idx_c) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) rd_fwd_c[8*b +: 8] = HWDATA[8*b +: 8];
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= S_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         ERR_COUNT <= '0;
         ws_cnt    <= '0;
         a_idx     <= '0;
         a_mask    <= '0;
         a_write   <= 1'b0;
      end else begin
         case (state)
            S_WAIT: begin
               if (ws_cnt == WSWIDTH'(1)) begin
                  state     <= S_DATA;
                  HREADYOUT <= 1'b1;
                  HRDATA    <= a_write ? '0 : mem[MAW'(a_idx)];
               end
               ws_cnt <= ws_cnt - WSWIDTH'(1);
            end
            S_ERR1: begin
               state     <= S_ERR2;
               HREADYOUT <= 1'b1;
            end
            default: begin
               // IDLE, DATA and ERR2 all complete a beat and may take the next one.
               if (accept_c) begin
                  a_idx   <= idx_c;
                  a_mask  <= mask_c;
                  a_write <= HWRITE;
                  if (err_c) begin
                     state     <= S_ERR1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                     HRDATA    <= '0;
                     if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + CNTWIDTH'(1);
                  end else if (WAIT_CFG == '0) begin
                     state     <= S_DATA;
                     HREADYOUT <= 1'b1;
                     HRESP     <= 1'b0;
                     HRDATA    <= HWRITE ? '0 : rd_fwd_c;
                  end else begin
                     state     <= S_WAIT;
                     ws_cnt    <= WAIT_CFG;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b0;
                     HRDATA    <= '0;
                  end
               end else begin
                  state     <= S_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= 1'b0;
                  HRDATA    <= '0;
               end
            end
         endcase
      end
   end

   // Byte-lane write at the end of the DATA cycle; contents survive reset.
   always_ff @(posedge HCLK) begin
      if (wr_commit_c) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) mem[MAW'(a_idx)][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
// Directed self-checking bench for ahb_slave_mem_ws (DEPTH=512, RO_WORDS=4).
module tb_ahb_slave_mem_ws;
   localparam int unsigned AW  = 12;
   localparam int unsigned DEP = 512;
   localparam int unsigned WSW = 4;
   localparam int unsigned RO  = 4;
   localparam int unsigned CW  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           hsel, hwrite, hreadyin, hreadyout, hresp;
   logic [AW-1:0]  haddr;
   logic [1:0]     htrans;
   logic [2:0]     hsize, hburst;
   logic [31:0]    hwdata, hrdata;
   logic [WSW-1:0] wait_cfg;
   logic [CW-1:0]  err_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [1:0]  rr0, rr;
   logic [31:0] rd0, rd;
   int          wt;

   always #5 clk = ~clk;
   assign hreadyin = hreadyout;

   ahb_slave_mem_ws #(
      .AWIDTH(AW), .DEPTH(DEP), .WSWIDTH(WSW), .RO_WORDS(RO), .CNTWIDTH(CW)
   ) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
      .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
      .HREADYIN(hreadyin), .WAIT_CFG(wait_cfg), .HREADYOUT(hreadyout),
      .HRDATA(hrdata), .HRESP(hresp), .ERR_COUNT(err_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One isolated transfer; WAIT_CFG is scrambled during the data phase.
   task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [WSW-1:0] ws,
                       output logic [1:0] o_rr0, output logic [31:0] o_rd0, output int o_wt,
                       output logic [1:0] o_rr, output logic [31:0] o_rd);
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; wait_cfg = ws;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00; hwdata = wd; wait_cfg = 4'd9;
      o_rr0 = {hreadyout, hresp};
      o_rd0 = hrdata;
      o_wt  = 0;
      while (!hreadyout && o_wt < 40) begin
         o_wt++;
         @(negedge clk);
      end
      o_rr = {hreadyout, hresp};
      o_rd = hrdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; haddr = '0; htrans = 2'b00;
      hsize = 3'b010; hburst = 3'b000; hwdata = '0; wait_cfg = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(hreadyout), 32'd1);
      check("rst_resp",  32'(hresp),     32'd0);
      check("rst_rdata", hrdata,         32'd0);
      check("rst_errcnt", 32'(err_count), 32'd0);
      rst = 1'b0;

      // Basic word write then read, zero wait
      xfer(1'b1, 12'h010, 3'b010, 32'hDEADBEEF, 4'd0, rr0, rd0, wt, rr, rd);
      check("w010_rr", 32'(rr), 32'h2);
      check("w010_wt", 32'(wt), 32'd0);
      check("w010_rd", rd, 32'd0);
      xfer(1'b0, 12'h010, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("r010_wt", 32'(wt), 32'd0);
      check("r010_rr", 32'(rr), 32'h2);
      check("r010_rd", rd, 32'hDEADBEEF);

      // Three wait states, WAIT_CFG changed mid-transfer
      xfer(1'b1, 12'h020, 3'b010, 32'h12345678, 4'd0, rr0, rd0, wt, rr, rd);
      xfer(1'b0, 12'h020, 3'b010, 32'h0, 4'd3, rr0, rd0, wt, rr, rd);
      check("ws3_wt",  32'(wt), 32'd3);
      check("ws3_rr0", 32'(rr0), 32'h0);
      check("ws3_rd0", rd0, 32'd0);
      check("ws3_rr",  32'(rr), 32'h2);
      check("ws3_rd",  rd, 32'h12345678);

      // Sub-word writes
      xfer(1'b1, 12'h040, 3'b010, 32'h11223344, 4'd0, rr0, rd0, wt, rr, rd);
      xfer(1'b1, 12'h041, 3'b000, 32'hAAAAAAAA, 4'd0, rr0, rd0, wt, rr, rd);
      check("wb041_rr", 32'(rr), 32'h2);
      xfer(1'b1, 12'h042, 3'b001, 32'hBBCCBBCC, 4'd1, rr0, rd0, wt, rr, rd);
      check("wh042_wt", 32'(wt), 32'd1);
      xfer(1'b0, 12'h040, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("r040_rd", rd, 32'hBBCCAA44);
      xfer(1'b0, 12'h042, 3'b001, 32'h0, 4'd2, rr0, rd0, wt, rr, rd);
      check("rh042_rd", rd, 32'hBBCCAA44);

      // Error responses
      xfer(1'b1, 12'h800, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("edepth_rr0", 32'(rr0), 32'h1);
      check("edepth_rr",  32'(rr),  32'h3);
      check("edepth_wt",  32'(wt),  32'd1);
      xfer(1'b1, 12'h003, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("emis_rr0", 32'(rr0), 32'h1);
      check("emis_rr",  32'(rr),  32'h3);
      xfer(1'b1, 12'h008, 3'b010, 32'hFFFFFFFF, 4'd2, rr0, rd0, wt, rr, rd);
      check("ero_rr0", 32'(rr0), 32'h1);
      check("ero_rr",  32'(rr),  32'h3);
      check("errcnt3", 32'(err_count), 32'd3);
      xfer(1'b1, 12'h011, 3'b001, 32'h0BAD0BAD, 4'd0, rr0, rd0, wt, rr, rd);
      check("ehalf_rr", 32'(rr), 32'h3);
      xfer(1'b0, 12'h010, 3'b011, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("esize_rr", 32'(rr), 32'h3);
      check("esize_rd", rd, 32'd0);
      check("errcnt5", 32'(err_count), 32'd5);
      xfer(1'b0, 12'h010, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("unchanged_rd", rd, 32'hDEADBEEF);
      xfer(1'b0, 12'h008, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("ro_read_rr", 32'(rr), 32'h2);
      xfer(1'b1, 12'h00C, 3'b000, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("ro_last_rr", 32'(rr), 32'h3);

      // Back-to-back write then read of the same word
      xfer(1'b1, 12'h080, 3'b010, 32'hCAFEF00D, 4'd0, rr0, rd0, wt, rr, rd);
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; haddr = 12'h080; hwrite = 1'b1; hsize = 3'b010; wait_cfg = '0;
      @(negedge clk);
      check("b2b_wr_ready", 32'(hreadyout), 32'd1);
      htrans = 2'b11; hwrite = 1'b0; hwdata = 32'h00000055;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00;
      check("b2b_rd_ready", 32'(hreadyout), 32'd1);
      check("b2b_rd_resp",  32'(hresp), 32'd0);
      check("b2b_rd_data",  hrdata, 32'h00000055);
      xfer(1'b0, 12'h080, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("b2b_commit", rd, 32'h00000055);

      // BUSY gives zero-wait OKAY
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b01;
      @(negedge clk);
      check("busy_rr", 32'({hreadyout, hresp}), 32'h2);
      hsel = 1'b0; htrans = 2'b00;

      // Reset during a wait state
      xfer(1'b1, 12'h0C0, 3'b010, 32'h77777777, 4'd0, rr0, rd0, wt, rr, rd);
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; haddr = 12'h0C0; hwrite = 1'b1; hsize = 3'b010; wait_cfg = 4'd5;
      @(negedge clk);
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12121212;
      check("rstw_stall", 32'(hreadyout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstw_ready", 32'(hreadyout), 32'd1);
      check("rstw_resp",  32'(hresp), 32'd0);
      check("rstw_errcnt", 32'(err_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      xfer(1'b0, 12'h0C0, 3'b010, 32'h0, 4'd0, rr0, rd0, wt, rr, rd);
      check("rstw_after_rr", 32'(rr), 32'h2);
      check("rstw_after_wt", 32'(wt), 32'd0);
      check("rstw_after_rd", rd, 32'h77777777);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
